// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory port, decode handshake, redirect
// and queue occupancy, bundled for the fetch_unit port list.
interface fetch_unit_if #(
   parameter int XLEN  = 32,
   parameter int ILEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [ILEN-1:0] imem_rdata;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [ILEN-1:0] out_insn;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   logic [CW-1:0]   occupancy;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      output out_valid,
      input  out_ready,
      output out_pc,
      output out_insn,
      input  redirect_valid,
      input  redirect_pc,
      output occupancy
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      input  out_valid,
      output out_ready,
      input  out_pc,
      input  out_insn,
      output redirect_valid,
      output redirect_pc,
      input  occupancy
   );
endinterface

// File: rtl/fetch_unit.sv
// Credit-controlled instruction fetch: issues reads to a sync-read imem
// and buffers {pc, insn} pairs in a DEPTH-entry queue for decode.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              ILEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0100_0000)
) (
   input  logic         clock,
   input  logic         reset,
   fetch_unit_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fetch_unit: DEPTH must be a power of two >= 2");
   end

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            inflight_q, inflight_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [ILEN-1:0] insn_mem [DEPTH];

   logic            req;
   logic            push;
   logic            pop;
   logic            head_valid;
   logic [CW:0]     credits_used;

   // Credits count both buffered entries and the read still in flight.
   assign credits_used = {1'b0, count_q} + (CW+1)'(inflight_q);
   assign req = !reset && !bus.redirect_valid
             && (credits_used < (CW+1)'(DEPTH));
   assign head_valid = (count_q != '0);
   assign pop  = head_valid && bus.out_ready;
   assign push = inflight_q && !bus.redirect_valid;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = inflight_q;
      inflight_pc_d = inflight_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
         inflight_d = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (req) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
         end else begin
            inflight_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   // Entry storage needs no reset; count gates what is visible.
   always_ff @(posedge clock) begin
      if (push && !reset) begin
         pc_mem[wr_ptr_q]   <= inflight_pc_q;
         insn_mem[wr_ptr_q] <= bus.imem_rdata;
      end
   end

   assign bus.imem_req  = req;
   assign bus.imem_addr = fetch_pc_q;
   assign bus.out_valid = head_valid;
   assign bus.out_pc    = head_valid ? pc_mem[rd_ptr_q] : '0;
   assign bus.out_insn  = head_valid ? insn_mem[rd_ptr_q] : '0;
   assign bus.occupancy = count_q;
endmodule
